// File: rtl/fft_scan_if.sv
// FFT scan sequencer bus: sample buffer, FFT core, result RAM, peak tracker.
// master = sequencer side, slave = surrounding datapath side.
interface fft_scan_if #(
  parameter int N         = 512,
  parameter int bit_width = 16,
  parameter int M         = $clog2(N)
);
  logic                        frame_ready;
  logic                        fft_start;
  logic                        fft_done;
  logic                        rd_en;
  logic [M-1:0]                rd_addr;
  logic signed [bit_width-1:0] rd_re;
  logic signed [bit_width-1:0] rd_im;
  logic                        peak_clr;
  logic                        load;
  logic [M-1:0]                bin_index;
  logic [2*bit_width-1:0]      mag2;
  logic                        done;
  logic                        busy;

  modport master (
    input  frame_ready,
    input  fft_done,
    input  rd_re,
    input  rd_im,
    output fft_start,
    output rd_en,
    output rd_addr,
    output peak_clr,
    output load,
    output bin_index,
    output mag2,
    output done,
    output busy
  );

  modport slave (
    output frame_ready,
    output fft_done,
    output rd_re,
    output rd_im,
    input  fft_start,
    input  rd_en,
    input  rd_addr,
    input  peak_clr,
    input  load,
    input  bin_index,
    input  mag2,
    input  done,
    input  busy
  );
endinterface

// File: rtl/fft_scan_ctrl.sv
// FFT launch / bin scan sequencer feeding the peak tracker with |X|^2.
// FFT_SCAN_DC_SKIP_EN: when defined, bin 0 (DC) is skipped by the scan.
module fft_scan_ctrl #(
  parameter int N         = 512,
  parameter int bit_width = 16,
  parameter int M         = $clog2(N)
) (
  input  logic      clk,
  input  logic      reset,
  fft_scan_if.master bus
);

  localparam int W2 = 2 * bit_width;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_FFT = 3'd1;
  localparam logic [2:0] CLEAR    = 3'd2;
  localparam logic [2:0] SCAN     = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

`ifdef FFT_SCAN_DC_SKIP_EN
  localparam logic [M-1:0] BIN_LO = M'(1);
`else
  localparam logic [M-1:0] BIN_LO = M'(0);
`endif
  localparam logic [M-1:0] BIN_HI = M'(N / 2 - 1);

  logic [2:0]           state;
  logic [2:0]           state_nx;
  logic                 drain_cnt;
  logic                 en_d1;
  logic [M-1:0]         addr_d1;
  logic signed [W2-1:0] re_x;
  logic signed [W2-1:0] im_x;
  logic signed [W2-1:0] re_sq;
  logic signed [W2-1:0] im_sq;
  logic [W2-1:0]        mag_sum;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (bus.frame_ready) state_nx = WAIT_FFT;
      WAIT_FFT: if (bus.fft_done) state_nx = CLEAR;
      CLEAR:    state_nx = SCAN;
      SCAN:     if (bus.rd_addr == BIN_HI) state_nx = DRAIN;
      DRAIN:    if (drain_cnt) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Each square fits in W2 signed bits; their sum fits W2 unsigned bits.
  always_comb begin
    re_x    = {{bit_width{bus.rd_re[bit_width-1]}}, bus.rd_re};
    im_x    = {{bit_width{bus.rd_im[bit_width-1]}}, bus.rd_im};
    re_sq   = re_x * re_x;
    im_sq   = im_x * im_x;
    mag_sum = $unsigned(re_sq) + $unsigned(im_sq);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      drain_cnt     <= 1'b0;
      bus.fft_start <= 1'b0;
      bus.peak_clr  <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.fft_start <= (state == IDLE) && bus.frame_ready;
      bus.peak_clr  <= (state_nx == CLEAR);
      bus.rd_en     <= (state_nx == SCAN);
      bus.done      <= (state_nx == DONE);
      bus.busy      <= (state_nx != IDLE);
      drain_cnt     <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == CLEAR)
        bus.rd_addr <= BIN_LO;
      else if (state == SCAN && bus.rd_addr != BIN_HI)
        bus.rd_addr <= bus.rd_addr + M'(1);
    end
  end

  // Stage 1 tracks the RAM read latency; stage 2 registers the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_d1         <= 1'b0;
      addr_d1       <= '0;
      bus.load      <= 1'b0;
      bus.bin_index <= '0;
      bus.mag2      <= '0;
    end else begin
      en_d1    <= bus.rd_en;
      addr_d1  <= bus.rd_addr;
      bus.load <= en_d1;
      if (en_d1) begin
        bus.bin_index <= addr_d1;
        bus.mag2      <= mag_sum;
      end
    end
  end

endmodule

// File: tb/tb_fft_scan_ctrl.sv
// Directed bench for fft_scan_ctrl with a behavioural result RAM.
// Works with or without FFT_SCAN_DC_SKIP_EN.
module tb_fft_scan_ctrl;

  localparam int N  = 512;
  localparam int BW = 16;
  localparam int M  = 9;
`ifdef FFT_SCAN_DC_SKIP_EN
  localparam int BIN_LO = 1;
`else
  localparam int BIN_LO = 0;
`endif
  localparam int BIN_HI = N / 2 - 1;
  localparam int K      = BIN_HI - BIN_LO + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails = 0;

  fft_scan_if #(.N(N), .bit_width(BW)) bus ();

  fft_scan_ctrl #(.N(N), .bit_width(BW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic int re_of(input int a);
    return (a == 0) ? -32768 : a;
  endfunction

  function automatic int im_of(input int a);
    if (a == 0) return -32768;
    return (a % 3 == 1) ? -a : 0;
  endfunction

  function automatic logic [31:0] exp_mag(input int a);
    longint re;
    longint im;
    re = longint'(re_of(a));
    im = longint'(im_of(a));
    return 32'(re * re + im * im);
  endfunction

  // Result RAM: one cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_re <= 16'(re_of(int'(bus.rd_addr)));
      bus.rd_im <= 16'(im_of(int'(bus.rd_addr)));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse fft_done now (cycle 0) and follow the scan through cycle K+6.
  task automatic scan(input int inj, input bit hold);
    int errs;
    int loads;
    int done_c;
    errs   = 0;
    loads  = 0;
    done_c = -1;
    bus.frame_ready = hold;
    bus.fft_done = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= K + 6; c++) begin
      bus.fft_done = (c == inj);
      if (bus.peak_clr !== (c == 1)) errs++;
      if (bus.rd_en !== (c >= 2 && c <= K + 1)) errs++;
      if (c >= 2 && c <= K + 1 && int'(bus.rd_addr) != BIN_LO + c - 2)
        errs++;
      if (bus.load !== (c >= 4 && c <= K + 3)) errs++;
      if (c >= 4 && c <= K + 3) begin
        if (int'(bus.bin_index) != BIN_LO + c - 4) errs++;
        if (bus.mag2 !== exp_mag(BIN_LO + c - 4)) errs++;
      end
      if (c > K + 3 && bus.mag2 !== exp_mag(BIN_HI)) errs++;
      if (bus.peak_clr === 1'b1 && bus.load === 1'b1) errs++;
      if (bus.done === 1'b1 && bus.load === 1'b1) errs++;
      if (bus.fft_start !== (hold && c == K + 6)) errs++;
      if (bus.load === 1'b1) loads++;
      if (bus.done === 1'b1) done_c = c;
      if (c == 1) chk("peak_clr_c1", 64'(bus.peak_clr), 64'd1);
      if (c == 2) chk("rd_addr_first", 64'(bus.rd_addr), 64'(BIN_LO));
      if (c == 4) begin
        chk("bin_first", 64'(bus.bin_index), 64'(BIN_LO));
        chk("mag_first", 64'(bus.mag2), 64'(exp_mag(BIN_LO)));
      end
      if (c == K + 1) chk("rd_addr_last", 64'(bus.rd_addr), 64'(BIN_HI));
      if (c == K + 4) begin
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("bin_hold", 64'(bus.bin_index), 64'(BIN_HI));
      end
      if (c == K + 5) chk("busy_idle", 64'(bus.busy), 64'd0);
      if (c == K + 6) chk("busy_next", 64'(bus.busy), 64'(hold));
      @(negedge clk);
    end
    bus.fft_done = 1'b0;
    chk("scan_cycle_errs", 64'(errs), 64'd0);
    chk("load_count", 64'(loads), 64'(K));
    chk("done_cycle", 64'(done_c), 64'(K + 4));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_start"}, 64'(bus.fft_start), 64'd0);
    chk({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    chk({tag, "_peak_clr"}, 64'(bus.peak_clr), 64'd0);
    chk({tag, "_load"}, 64'(bus.load), 64'd0);
    chk({tag, "_bin"}, 64'(bus.bin_index), 64'd0);
    chk({tag, "_mag2"}, 64'(bus.mag2), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int seen;
    bus.frame_ready = 1'b0;
    bus.fft_done    = 1'b0;
    bus.rd_re       = '0;
    bus.rd_im       = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    // fft_done while idle is ignored
    bus.fft_done = 1'b1;
    @(negedge clk);
    bus.fft_done = 1'b0;
    seen = 0;
    repeat (3) begin
      if (bus.busy !== 1'b0 || bus.fft_start !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("idle_done_ignored", 64'(seen), 64'd0);

    // launch: one fft_start, then none while waiting
    bus.frame_ready = 1'b1;
    @(negedge clk);
    chk("start_pulse", 64'(bus.fft_start), 64'd1);
    chk("start_busy", 64'(bus.busy), 64'd1);
    bus.frame_ready = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.fft_start !== 1'b0) seen++;
    end
    chk("no_second_start", 64'(seen), 64'd0);
    chk("wait_busy", 64'(bus.busy), 64'd1);

    // full scan with a stray fft_done mid-scan
    scan(50, 1'b0);

    // frame_ready held high across two frames
    bus.frame_ready = 1'b1;
    @(negedge clk);
    chk("hold_start1", 64'(bus.fft_start), 64'd1);
    @(negedge clk);
    scan(0, 1'b1);
    scan(0, 1'b0);
    seen = 0;
    repeat (4) begin
      if (bus.fft_start !== 1'b0 || bus.busy !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("hold_released_idle", 64'(seen), 64'd0);

    // asynchronous reset in the middle of a scan
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    @(negedge clk);
    bus.fft_done = 1'b1;
    @(negedge clk);
    bus.fft_done = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_reset_load", 64'(bus.load), 64'd1);
    #2 reset = 1'b0;
    #1 chk_zero_outputs("midscan_rst");
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.load !== 1'b0)
        seen++;
    end
    chk("post_reset_idle", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fft_scan_ctrl.md
# fft_scan_ctrl

Sequencer for the tuner's spectral back end. It does four things in order:
- launches an FFT frame when the sample buffer reports a full frame;
- waits for the FFT core to finish;
- clears the peak tracker;
- streams bins from the FFT result RAM, computes magnitude-squared and drives the peak tracker's `load`/`bin_index`/`mag2`/`done` interface.

It sits between the sample buffer, the FFT core/result RAM and the peak tracker.

## Interface
Parameters:
- `N`, 512, FFT length (power of two, ≥ 8)
- `bit_width`, 16, signed width of real/imag FFT outputs
- `M`, `$clog2(N)`, bin address width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `frame_ready`  in  1  sample buffer holds a full frame (level)
- `fft_start`  out  1  one-cycle pulse launching the FFT core
- `fft_done`  in  1  one-cycle pulse from the FFT core at frame completion
- `rd_en`  out  1  result RAM read enable
- `rd_addr`  out  M  result RAM bin address
- `rd_re`  in  bit_width  signed real part, valid 1 cycle after `rd_en`
- `rd_im`  in  bit_width  signed imag part, valid 1 cycle after `rd_en`
- `peak_clr`  out  1  one-cycle pulse, drives the peak tracker's (active-high) reset
- `load`  out  1  peak tracker load, high while `mag2`/`bin_index` are valid
- `bin_index`  out  M  bin of current `mag2`
- `mag2`  out  2*bit_width  unsigned re²+im²
- `done`  out  1  one-cycle pulse after the last `load`
- `busy`  out  1  high in every state except IDLE

## Operation
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
- The scan range is BIN_LO..BIN_HI:
  - BIN_HI = N/2−1;
  - BIN_LO per Configuration;
  - K = BIN_HI−BIN_LO+1 bins.

States:
- IDLE: if `frame_ready`=1, pulse `fft_start` and go to WAIT_FFT.
- WAIT_FFT: on `fft_done`=1, go to CLEAR. `fft_done` in any other state is ignored.
- CLEAR: assert `peak_clr` for one cycle, load the address counter with BIN_LO, go to SCAN.
- SCAN: `rd_en`=1 and `rd_addr`=counter each cycle, counter +1. After issuing BIN_HI, go to DRAIN. The counter never wraps past BIN_HI.
- DRAIN: stay 2 cycles with `rd_en`=0 while the pipeline empties, then go to DONE.
- DONE: assert `done` for one cycle, go to IDLE.

Datapath (2-stage pipeline):
- Stage 1: the address is delayed one cycle alongside the RAM read.
- Stage 2: compute squares and sum into the `mag2` register.
- Stage 2 also registers `bin_index` = delayed address and `load` = rd_en delayed 2 cycles.

Arithmetic:
- rd_re² and rd_im² are full-precision signed products, each ≤ 2^(2·bit_width−2).
- The sum is unsigned 2*bit_width wide and never overflows. Worst case −2^(bw−1) on both inputs gives 2^(2bw−1).

Output behaviour:
- `mag2` and `bin_index` hold their last values when `load`=0.
- `frame_ready` is sampled only in IDLE. If it stays high, a new frame launches the cycle after DONE.
- Reset asserted mid-scan asynchronously zeroes all outputs, including `load` and `done`, and returns the FSM to IDLE. No partial `done` is ever issued.

## Timing
Cycle 0 is the cycle in which `fft_done`=1 is sampled in WAIT_FFT.

| Cycle | Event |
|---|---|
| 1 | `peak_clr`=1 |
| 2 … K+1 | `rd_en`=1, `rd_addr` = BIN_LO … BIN_HI |
| 4 … K+3 | `load`=1, `bin_index` = BIN_LO … BIN_HI |
| K+4 | `done`=1 (exactly one cycle after the final `load`, so the tracker latches the updated max) |
| K+5 | back in IDLE, `busy`=0 |
| K+6 | earliest next `fft_start` |

- `fft_start` appears the cycle after `frame_ready` is sampled high in IDLE.
- `peak_clr` and `load` are never high in the same cycle.
- `done` and `load` are never high in the same cycle.

## Configuration
Macro `FFT_SCAN_DC_SKIP_EN`:
- Defined: BIN_LO=1, so DC bin 0 is never read or loaded. K=N/2−1, which is 255 for N=512.
- Undefined: BIN_LO=0, K=N/2, which is 256 for N=512.

## Test plan
All cases use N=512, bit_width=16 unless noted.
1. Reset, then `frame_ready`=1: `fft_start` pulses once, `busy`=1, and there is no further `fft_start` until `done`.
2. Macro defined, RAM bin b holds re=b, im=0, then `fft_done` pulse: `peak_clr` in cycle 1; `rd_addr` 1→255; `load` high for exactly 255 cycles with `bin_index`=1…255 and `mag2`=b²; `done` in cycle 259.
3. Macro undefined, bin 0 holds re=−32768, im=−32768: first `mag2`=0x8000_0000 with `bin_index`=0; `load` high for 256 cycles; `done` in cycle 260.
4. Two `fft_done` pulses, one in IDLE and one mid-SCAN: both ignored, and the scan sequence and counts are unchanged.
5. Reset driven low during SCAN: all outputs are 0 immediately. After release, with `frame_ready`=0, the block stays IDLE with `done` never asserted.
6. `frame_ready` held high across two frames: second `fft_start` arrives exactly 2 cycles after the first `done`, and `peak_clr` precedes each scan.
